// File: rtl/ro_puf_pkg.sv
// Shared definitions for the RO PUF measurement stage: FSM states,
// default sizing constants and the timer width helper.
package ro_puf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_CNT_W         = 16;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_WINDOW_CYCLES = 1024;

  // Width needed by the shared down-counting timer so that it can hold the
  // longer of the two phase lengths.
  function automatic int timerWidth(input int settleCycles, input int windowCycles);
    int maxVal;
    maxVal = (settleCycles > windowCycles) ? settleCycles : windowCycles;
    return $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// One oscillator channel: 2-flop synchronizer, rising-edge detector and a
// saturating edge counter with a sticky saturation flag. The outputs show
// the value the counter and flag take at the next clock edge, so the
// parent can capture a result that includes an edge seen in the final
// counting cycle.
module ro_edge_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_ro,
  input  logic             i_clear,
  input  logic             i_countEn,
  output logic [CNT_W-1:0] o_countNext,
  output logic             o_satNext
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_count;
  logic             r_sat;
  logic             w_edge;

  assign w_edge = r_sync2 & ~r_prev;

  // Bring the asynchronous oscillator into the clock domain and keep the
  // previous synchronized value for edge detection.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_ro;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Next counter state: clear wins, otherwise count enabled edges and stop
  // at the ceiling, flagging any edge that arrives once the ceiling is hit.
  always_comb begin
    o_countNext = r_count;
    o_satNext   = r_sat;
    if (i_clear) begin
      o_countNext = '0;
      o_satNext   = 1'b0;
    end else if (i_countEn && w_edge) begin
      if (r_count == CNT_MAX) begin
        o_satNext = 1'b1;
      end else begin
        o_countNext = r_count + CNT_W'(1);
      end
    end
  end

  // Counter and sticky saturation registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_count <= o_countNext;
      r_sat   <= o_satNext;
    end
  end

endmodule

// File: rtl/ro_pair_compare.sv
// Ring-oscillator pair measurement stage. Enables both oscillators, lets
// the synchronizers settle, counts edges of each over a fixed window and
// publishes the comparison as one PUF response bit with raw counts and
// tie/saturation flags, under a Start/Busy/Done handshake.
module ro_pair_compare
  import ro_puf_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             RO_a,
  input  logic             RO_b,
  output logic             RO_en,
  output logic             Busy,
  output logic             Done,
  output logic             Response,
  output logic             Tie,
  output logic             Sat,
  output logic [CNT_W-1:0] Count_a,
  output logic [CNT_W-1:0] Count_b
);

  localparam int TIMER_W = timerWidth(SETTLE_CYCLES, WINDOW_CYCLES);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WINDOW_LOAD = TIMER_W'(WINDOW_CYCLES - 1);

  state_t             r_state;
  state_t             w_nextState;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_timerNext;
  logic               w_clear;
  logic               w_countEn;
  logic               w_latch;
  logic [CNT_W-1:0]   w_countNextA;
  logic [CNT_W-1:0]   w_countNextB;
  logic               w_satNextA;
  logic               w_satNextB;

  ro_edge_counter #(.CNT_W(CNT_W)) u_counterA (
    .i_clock     (Clk),
    .i_reset     (Reset),
    .i_ro        (RO_a),
    .i_clear     (w_clear),
    .i_countEn   (w_countEn),
    .o_countNext (w_countNextA),
    .o_satNext   (w_satNextA)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_counterB (
    .i_clock     (Clk),
    .i_reset     (Reset),
    .i_ro        (RO_b),
    .i_clear     (w_clear),
    .i_countEn   (w_countEn),
    .o_countNext (w_countNextB),
    .o_satNext   (w_satNextB)
  );

  // State and shared phase timer registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_nextState;
      r_timer <= w_timerNext;
    end
  end

  // Next state, timer reload/decrement and the handshake/enable outputs.
  // The timer counts down to zero in each timed phase; zero ends the phase.
  always_comb begin
    w_nextState = r_state;
    w_timerNext = r_timer;
    w_clear     = 1'b0;
    w_countEn   = 1'b0;
    w_latch     = 1'b0;
    RO_en       = 1'b0;
    Busy        = 1'b0;
    Done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start) begin
          w_nextState = SETTLE;
          w_clear     = 1'b1;
          w_timerNext = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        RO_en = 1'b1;
        Busy  = 1'b1;
        if (r_timer == '0) begin
          w_nextState = COUNT;
          w_timerNext = WINDOW_LOAD;
        end else begin
          w_timerNext = r_timer - TIMER_W'(1);
        end
      end
      COUNT: begin
        RO_en     = 1'b1;
        Busy      = 1'b1;
        w_countEn = 1'b1;
        if (r_timer == '0) begin
          w_nextState = DONE;
          w_latch     = 1'b1;
        end else begin
          w_timerNext = r_timer - TIMER_W'(1);
        end
      end
      DONE: begin
        Busy        = 1'b1;
        Done        = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Result registers, captured on the last counting edge so they are valid
  // during the Done cycle and held until the next run completes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Count_a  <= '0;
      Count_b  <= '0;
      Response <= 1'b0;
      Tie      <= 1'b0;
      Sat      <= 1'b0;
    end else if (w_latch) begin
      Count_a  <= w_countNextA;
      Count_b  <= w_countNextB;
      Response <= (w_countNextA > w_countNextB);
      Tie      <= (w_countNextA == w_countNextB);
      Sat      <= w_satNextA | w_satNextB;
    end
  end

endmodule

// File: tb/tb_ro_pair_compare.sv
// Scoreboard bench for ro_pair_compare: stimulus pushes the expected result
// of each run into a queue; monitors pop and compare on every Done pulse.
module tb_ro_pair_compare;

  localparam int PERIOD  = 10;
  localparam int LATENCY = 1029;
  localparam int SPACING = 1030;

  typedef struct {
    int startEdge;
    int expA;
    int expB;
    int tolA;
    int tolB;
    bit expResp;
    bit expTie;
    bit expSat;
    bit mustEqual;
  } exp_t;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic        startSat;
  logic        p4, p6, p8, p100;
  logic        roA, roB;
  int          mode;

  logic        roEn, busy, done, response, tie, sat;
  logic [15:0] countA, countB;
  logic        satRoEn, satBusy, satDone, satResponse, satTie, satFlag;
  logic [3:0]  satCountA, satCountB;

  int   cycleCnt = 0;
  int   nChecks  = 0;
  int   nFail    = 0;
  int   mainDones = 0;
  int   satDones  = 0;
  exp_t mainQ[$];
  exp_t satQ[$];
  exp_t mainE;
  exp_t satE;

  ro_pair_compare dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .RO_a(roA), .RO_b(roB),
    .RO_en(roEn), .Busy(busy), .Done(done), .Response(response),
    .Tie(tie), .Sat(sat), .Count_a(countA), .Count_b(countB)
  );

  ro_pair_compare #(.CNT_W(4)) dutSat (
    .Clk(Clk), .Reset(Reset), .Start(startSat), .RO_a(p4), .RO_b(p100),
    .RO_en(satRoEn), .Busy(satBusy), .Done(satDone), .Response(satResponse),
    .Tie(satTie), .Sat(satFlag), .Count_a(satCountA), .Count_b(satCountB)
  );

  // System clock and free-running oscillator stand-ins, phase-offset so
  // their transitions never coincide with a clock edge.
  initial begin Clk = 1'b0; forever #(PERIOD/2) Clk = ~Clk; end
  initial begin p4 = 1'b0; #3; forever #20 p4 = ~p4; end
  initial begin p6 = 1'b0; #3; forever #30 p6 = ~p6; end
  initial begin p8 = 1'b0; #3; forever #40 p8 = ~p8; end
  initial begin p100 = 1'b0; #3; forever #500 p100 = ~p100; end

  always @(posedge Clk) cycleCnt <= cycleCnt + 1;

  // Oscillator routing for the main instance: normal, swapped, shared source.
  always_comb begin
    roA = p4;
    roB = p8;
    case (mode)
      1: begin roA = p8; roB = p4; end
      2: begin roA = p6; roB = p6; end
      default: ;
    endcase
  end

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic checkRange(input string name, input int act, input int exp, input int tol);
    nChecks++;
    if (act < exp - tol || act > exp + tol) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, required %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e, input int actA, input int actB,
                             input logic resp, input logic tieV, input logic satV, input int cyc);
    checkValue({tag, "Latency"}, cyc - e.startEdge + 1, LATENCY);
    checkRange({tag, "CountA"}, actA, e.expA, e.tolA);
    checkRange({tag, "CountB"}, actB, e.expB, e.tolB);
    checkValue({tag, "Response"}, 32'(resp), 32'(e.expResp));
    checkValue({tag, "Tie"}, 32'(tieV), 32'(e.expTie));
    checkValue({tag, "Sat"}, 32'(satV), 32'(e.expSat));
    if (e.mustEqual) checkValue({tag, "CountsEqual"}, actA, actB);
  endtask

  // Main-instance monitor.
  always @(negedge Clk) begin
    if (done === 1'b1) begin
      mainDones++;
      if (mainQ.size() == 0) begin
        nChecks++;
        nFail++;
        $display("[TB] FAIL mainUnexpectedDone: Done at cycle %0d, required none", cycleCnt);
      end else begin
        mainE = mainQ.pop_front();
        checkOutput("main", mainE, int'(countA), int'(countB), response, tie, sat, cycleCnt);
      end
    end
  end

  // Narrow-counter instance monitor.
  always @(negedge Clk) begin
    if (satDone === 1'b1) begin
      satDones++;
      if (satQ.size() == 0) begin
        nChecks++;
        nFail++;
        $display("[TB] FAIL satUnexpectedDone: Done at cycle %0d, required none", cycleCnt);
      end else begin
        satE = satQ.pop_front();
        checkOutput("sat", satE, int'(satCountA), int'(satCountB), satResponse, satTie, satFlag, cycleCnt);
      end
    end
  end

  task automatic waitDrain(input bit useSat, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((useSat ? satQ.size() : mainQ.size()) == 0) break;
      @(negedge Clk);
    end
    checkValue(useSat ? "satDoneTimeout" : "mainDoneTimeout",
               useSat ? satQ.size() : mainQ.size(), 0);
    if (useSat) satQ.delete(); else mainQ.delete();
  endtask

  task automatic applyStimulus(input bit useSat, input int newMode, input int expA, input int tolA,
                               input int expB, input int tolB, input bit resp, input bit tieV,
                               input bit satV, input bit mustEq, input int repulseAt);
    exp_t e;
    @(negedge Clk);
    mode = newMode;
    repeat (4) @(negedge Clk);
    e.startEdge = cycleCnt + 1;
    e.expA = expA; e.tolA = tolA;
    e.expB = expB; e.tolB = tolB;
    e.expResp = resp; e.expTie = tieV; e.expSat = satV; e.mustEqual = mustEq;
    if (useSat) begin satQ.push_back(e); startSat = 1'b1; end
    else begin mainQ.push_back(e); Start = 1'b1; end
    @(negedge Clk);
    Start = 1'b0;
    startSat = 1'b0;
    checkValue("busyCycle1", 32'(useSat ? satBusy : busy), 1);
    checkValue("roEnCycle1", 32'(useSat ? satRoEn : roEn), 1);
    if (repulseAt > 0) begin
      repeat (repulseAt) @(negedge Clk);
      if (useSat) startSat = 1'b1; else Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      startSat = 1'b0;
    end
    waitDrain(useSat, 1200);
    @(negedge Clk);
    checkValue("busyAfterDone", 32'(useSat ? satBusy : busy), 0);
    checkValue("roEnAfterDone", 32'(useSat ? satRoEn : roEn), 0);
    checkValue("holdResponse", 32'(useSat ? satResponse : response), 32'(resp));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e1, e2;
    int donesBefore;
    Reset = 1'b1;
    Start = 1'b0;
    startSat = 1'b0;
    mode = 0;
    repeat (3) @(negedge Clk);
    checkValue("resetBusy", 32'(busy), 0);
    checkValue("resetRoEn", 32'(roEn), 0);
    checkValue("resetDone", 32'(done), 0);
    checkValue("resetCountA", 32'(countA), 0);
    checkValue("resetSatBusy", 32'(satBusy), 0);
    Reset = 1'b0;

    // Window count, swapped inputs, tie, narrow-counter saturation.
    applyStimulus(0, 0, 256, 1, 128, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 128, 1, 256, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 2, 171, 1, 171, 1, 0, 1, 0, 1, 0);
    applyStimulus(1, 0, 15, 0, 10, 1, 1, 0, 1, 0, 0);

    // Start re-pulsed mid-COUNT is ignored: exactly one Done.
    donesBefore = mainDones;
    applyStimulus(0, 0, 256, 1, 128, 1, 1, 0, 0, 0, 500);
    repeat (1100) @(negedge Clk);
    checkValue("ignoredStartDones", mainDones - donesBefore, 1);

    // Start held high: back-to-back runs, then reset in the middle of the third.
    @(negedge Clk);
    mode = 0;
    e1.startEdge = cycleCnt + 1;
    e1.expA = 256; e1.tolA = 1; e1.expB = 128; e1.tolB = 1;
    e1.expResp = 1; e1.expTie = 0; e1.expSat = 0; e1.mustEqual = 0;
    e2 = e1;
    e2.startEdge = e1.startEdge + SPACING;
    mainQ.push_back(e1);
    mainQ.push_back(e2);
    Start = 1'b1;
    waitDrain(0, 2300);
    repeat (600) @(negedge Clk);
    checkValue("busyBeforeReset", 32'(busy), 1);
    Start = 1'b0;
    Reset = 1'b1;
    donesBefore = mainDones;
    @(negedge Clk);
    checkValue("midResetRoEn", 32'(roEn), 0);
    checkValue("midResetBusy", 32'(busy), 0);
    checkValue("midResetDone", 32'(done), 0);
    checkValue("midResetResponse", 32'(response), 0);
    checkValue("midResetTie", 32'(tie), 0);
    checkValue("midResetSat", 32'(sat), 0);
    checkValue("midResetCountA", 32'(countA), 0);
    checkValue("midResetCountB", 32'(countB), 0);
    Reset = 1'b0;
    repeat (1100) @(negedge Clk);
    checkValue("noDoneAfterReset", mainDones - donesBefore, 0);
    checkValue("satTotalDones", satDones, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
